// File: rtl/code_lock_fsm.sv
// Combination-lock sequence checker: consumes key-press pulses, compares them with SECRET, drives the lock.
// Optional failed-attempt lockout is built when CODE_LOCK_LOCKOUT_EN is defined.
module code_lock_fsm #(
    parameter int unsigned              CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]    SECRET         = 8'b11_10_01_00,
    parameter int unsigned              UNLOCK_CYCLES  = 8,
    parameter int unsigned              MAX_FAILS      = 3,
    parameter int unsigned              LOCKOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            key_valid,
    input  logic [1:0]                      key_code,
    input  logic                            key_clear,
    output logic                            unlocked,
    output logic                            error,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_count
);

    localparam int unsigned CNT_W     = $clog2(CODE_LEN + 1);
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned FAIL_W    = $clog2(MAX_FAILS + 1);
`else
    localparam int unsigned TIMER_MAX = UNLOCK_CYCLES;
`endif
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    // Parameter sanity checks at elaboration
    if (CODE_LEN < 1 || CODE_LEN > 8) begin : g_bad_code_len
        $error("code_lock_fsm: CODE_LEN must be 1..8");
    end
    if (UNLOCK_CYCLES < 1) begin : g_bad_unlock
        $error("code_lock_fsm: UNLOCK_CYCLES must be >= 1");
    end
    if (MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_lockout
        $error("code_lock_fsm: MAX_FAILS and LOCKOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 mismatch;
    logic [TIMER_W-1:0]   timer;
    logic [1:0]           secret_digit;
    logic                 last_digit;
    logic                 digit_bad;
`ifdef CODE_LOCK_LOCKOUT_EN
    logic [FAIL_W-1:0]    fails;
`endif

    // Secret digit expected at the current entry position
    always_comb begin
        secret_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (count == CNT_W'(i)) begin
                secret_digit = SECRET[2*i +: 2];
            end
        end
    end

    assign last_digit  = (32'(count) == CODE_LEN - 1);
    assign digit_bad   = (key_code != secret_digit);
    assign digit_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ENTRY;
            count    <= '0;
            mismatch <= 1'b0;
            timer    <= '0;
            unlocked <= 1'b0;
            error    <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
            fails      <= '0;
            locked_out <= 1'b0;
`endif
        end else begin
            error <= 1'b0;
            case (state)
                ENTRY: begin
                    if (key_clear) begin
                        count    <= '0;
                        mismatch <= 1'b0;
                    end else if (key_valid) begin
                        if (last_digit) begin
                            count    <= '0;
                            mismatch <= 1'b0;
                            if (mismatch || digit_bad) begin
                                // Reject only after the full code, never earlier
                                error <= 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                                fails <= fails + FAIL_W'(1);
                                if (32'(fails) + 1 >= MAX_FAILS) begin
                                    state      <= LOCKOUT;
                                    timer      <= TIMER_W'(LOCKOUT_CYCLES);
                                    locked_out <= 1'b1;
                                end
`endif
                            end else begin
                                state    <= OPEN;
                                timer    <= TIMER_W'(UNLOCK_CYCLES);
                                unlocked <= 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                                fails    <= '0;
`endif
                            end
                        end else begin
                            count <= count + CNT_W'(1);
                            if (digit_bad) begin
                                mismatch <= 1'b1;
                            end
                        end
                    end
                end
                OPEN: begin
                    timer <= timer - TIMER_W'(1);
                    if (timer == TIMER_W'(1)) begin
                        state    <= ENTRY;
                        unlocked <= 1'b0;
                    end
                end
`ifdef CODE_LOCK_LOCKOUT_EN
                LOCKOUT: begin
                    timer <= timer - TIMER_W'(1);
                    if (timer == TIMER_W'(1)) begin
                        state      <= ENTRY;
                        locked_out <= 1'b0;
                        fails      <= '0;
                    end
                end
`endif
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

`ifndef CODE_LOCK_LOCKOUT_EN
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_fsm.sv
// Self-checking bench for code_lock_fsm: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a digit-queue reference model.
module tb_code_lock_fsm;

    localparam int unsigned CODE_LEN       = 4;
    localparam logic [7:0]  SECRET         = 8'b11_10_01_00;
    localparam int unsigned UNLOCK_CYCLES  = 8;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 16;
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key_code = 2'd0;
    logic       key_clear = 1'b0;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    code_lock_fsm #(
        .CODE_LEN      (CODE_LEN),
        .SECRET        (SECRET),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .MAX_FAILS     (MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_clear  (key_clear),
        .unlocked   (unlocked),
        .error      (error),
        .locked_out (locked_out),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    function automatic int sdig(input int i);
        logic [7:0] s;
        s = SECRET;
        return int'(s[2*i +: 2]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entered digits in a queue, remaining open/lockout cycles as plain counters
    int entry[$];
    int open_left = 0;
    int lock_left = 0;
    int fails     = 0;
    bit e_err     = 1'b0;

    always @(posedge clk) begin
        bit ok;
        e_err = 1'b0;
        if (reset) begin
            entry.delete();
            open_left = 0;
            lock_left = 0;
            fails     = 0;
        end else if (open_left > 0) begin
            open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (key_clear) begin
            entry.delete();
        end else if (key_valid) begin
            entry.push_back(int'(key_code));
            if (entry.size() == CODE_LEN) begin
                ok = 1'b1;
                foreach (entry[i]) if (entry[i] != sdig(i)) ok = 1'b0;
                entry.delete();
                if (ok) begin
                    open_left = UNLOCK_CYCLES;
                    fails     = 0;
                end else begin
                    e_err = 1'b1;
                    fails++;
                    if (LOCK_EN && fails >= MAX_FAILS) lock_left = LOCKOUT_CYCLES;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_unlocked",    int'(unlocked),    int'(open_left > 0));
            check("m_error",       int'(error),       int'(e_err));
            check("m_locked_out",  int'(locked_out),  int'(lock_left > 0));
            check("m_digit_count", int'(digit_count), entry.size());
        end
    end

    task automatic step(input logic v, input logic [1:0] c, input logic clr, input logic rst);
        key_valid = v;
        key_code  = c;
        key_clear = clr;
        reset     = rst;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_clear = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic key(input int c);
        step(1'b1, 2'(c), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [7:0] c);
        for (int i = 0; i < 4; i++) key(int'(c[2*i +: 2]));
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((unlocked || locked_out) && g < 40) begin
            idle(1);
            g++;
        end
        check("wait_idle", int'(unlocked | locked_out), 0);
    endtask

    initial begin
        int hi;
        int errs;

        // Reset state
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_error", int'(error), 0);
        check("rst_locked_out", int'(locked_out), 0);
        check("rst_digit_count", int'(digit_count), 0);
        idle(5);

        // Correct code with gaps; keys while open are ignored
        key(0); check("ok_dc1", int'(digit_count), 1); idle(1);
        key(1); check("ok_dc2", int'(digit_count), 2); idle(1);
        key(2); check("ok_dc3", int'(digit_count), 3); idle(1);
        key(3);
        check("ok_unlocked", int'(unlocked), 1);
        check("ok_dc0", int'(digit_count), 0);
        check("ok_no_error", int'(error), 0);
        hi = 0;
        while (unlocked && hi < 40) begin
            hi++;
            key(int'($urandom_range(0, 3)));
        end
        check("ok_open_cycles", hi, 8);
        check("ok_keys_ignored", int'(digit_count), 0);

        // Wrong final digit, then the right code
        enter_code(8'b00_10_01_00);
        check("bad_error", int'(error), 1);
        check("bad_unlocked", int'(unlocked), 0);
        idle(1);
        check("bad_error_pulse", int'(error), 0);
        enter_code(SECRET);
        check("bad_then_ok", int'(unlocked), 1);
        wait_idle();

        // Clear mid-entry
        key(0); key(1);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("clr_dc", int'(digit_count), 0);
        check("clr_no_error", int'(error), 0);
        enter_code(SECRET);
        check("clr_then_ok", int'(unlocked), 1);
        wait_idle();

        // Clear on the same cycle as the third key drops the key
        key(0); key(1);
        step(1'b1, 2'd2, 1'b1, 1'b0);
        check("clr_key_dc", int'(digit_count), 0);
        idle(2);

        // Repeated rejections: lockout when enabled, endless errors otherwise
        errs = 0;
        for (int k = 0; k < (LOCK_EN ? 3 : 5); k++) begin
            enter_code(8'b01_01_01_01);
            errs += int'(error);
            if (k == 2) check("lo_rise_with_error", int'(locked_out), int'(LOCK_EN));
        end
        check("lo_error_pulses", errs, LOCK_EN ? 3 : 5);
        hi = 0;
        while (locked_out && hi < 40) begin
            hi++;
            key(int'($urandom_range(0, 3)));
        end
        check("lo_cycles", hi, LOCK_EN ? 16 : 0);
        check("lo_keys_ignored", int'(digit_count), 0);
        enter_code(SECRET);
        check("lo_then_ok", int'(unlocked), 1);

        // Reset mid-open
        idle(3);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("rst_open_unlocked", int'(unlocked), 0);
        check("rst_open_dc", int'(digit_count), 0);

        // Reset after two digits also clears the fail count
        enter_code(8'b00_00_00_00);
        enter_code(8'b00_00_00_00);
        key(0); key(1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("rst_entry_dc", int'(digit_count), 0);
        enter_code(8'b00_00_00_00);
        enter_code(8'b00_00_00_00);
        check("rst_fails_cleared", int'(locked_out), 0);
        enter_code(8'b00_00_00_00);
        check("rst_third_fail", int'(locked_out), int'(LOCK_EN));
        wait_idle();

        // Randomized traffic, mostly correct digits so all states are visited
        for (int n = 0; n < 4000; n++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 999));
            c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : sdig(entry.size());
            step(1'b1 && (r < 600), 2'(c), $urandom_range(0, 24) == 0, r == 999);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Sequence checker for the combination lock: reads the one-cycle key-press events produced by the button front end, accumulates them against a stored secret code, and decides unlock or reject. It is the consumer side of the key-press interface. It owns all lock state: digit position, mismatch memory, unlock hold timer and failed-attempt lockout. It drives the lock actuator and status indicators directly.

## Interface
- `CODE_LEN`, 4: digits per code, 1..8.
- `SECRET`, 8'b11_10_01_00: packed code, 2 bits per digit, 2*CODE_LEN wide; digit 0 (first entered) in bits [1:0].
- `UNLOCK_CYCLES`, 8: cycles `unlocked` stays high, ≥1.
- `MAX_FAILS`, 3: consecutive rejected codes that trigger lockout, ≥1.
- `LOCKOUT_CYCLES`, 16: lockout duration in cycles, ≥1.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `key_valid`  in  1  one-cycle pulse: a key was pressed.
- `key_code`  in  2  key identity, sampled only when `key_valid`=1.
- `key_clear`  in  1  one-cycle pulse: abandon current entry.
- `unlocked`  out  1  lock open (registered).
- `error`  out  1  one-cycle pulse: completed code rejected.
- `locked_out`  out  1  lockout active; keys ignored.
- `digit_count`  out  $clog2(CODE_LEN+1)  digits accepted in current entry.

## Operation
- States: ENTRY, OPEN, LOCKOUT. Reset → ENTRY. All outputs are 0 on reset; counters are 0 and the mismatch flag is cleared.
- ENTRY, `key_valid`=1 with count < CODE_LEN-1:
  - count increments.
  - mismatch flag is set if `key_code` ≠ SECRET digit[count].
- ENTRY, `key_valid`=1 on the last digit:
  - The final compare includes this digit.
  - On match: go to OPEN, load the hold timer with UNLOCK_CYCLES, clear the fail count.
  - On mismatch: pulse `error`, increment the fail count, stay in ENTRY.
  - In both cases count and the mismatch flag clear.
- No early rejection: `error` only appears after all CODE_LEN digits, so a wrong digit position is never revealed.
- `key_clear` in ENTRY: count and mismatch flag clear. The fail count is unchanged. No `error` pulse.
- `key_valid` and `key_clear` in the same cycle: clear wins and the key is dropped.
- OPEN:
  - `unlocked`=1; keys and clears are ignored.
  - The timer decrements each cycle; at expiry go to ENTRY.
  - `unlocked` is high for exactly UNLOCK_CYCLES cycles.
- LOCKOUT (macro only):
  - `locked_out`=1; keys and clears are ignored.
  - After LOCKOUT_CYCLES cycles go to ENTRY with the fail count at 0.
- `digit_count` reads 0 outside ENTRY.
- Reset asserted in any state, mid-entry or mid-timer: next cycle is ENTRY with all outputs 0.

## Timing
- Digit accept: `digit_count` updates the cycle after `key_valid`.
- Last-digit latency is one cycle:
  - Match: `unlocked` rises the cycle after the final `key_valid`.
  - Mismatch: `error` is high for that one cycle only.
- Keys are accepted again in the first cycle after `unlocked` falls.
- Lockout entry: `locked_out` rises in the same cycle as the `error` pulse that brings the fail count to MAX_FAILS.
- `key_valid` arriving on consecutive cycles is legal; every pulse in ENTRY is consumed.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `CODE_LOCK_LOCKOUT_EN`.
- Defined:
  - The fail counter and LOCKOUT state are built.
  - The MAX_FAILS-th consecutive rejection enters LOCKOUT.
- Undefined:
  - No fail counter and no LOCKOUT state; `locked_out` is tied to 0.
  - A rejection pulses `error` and stays in ENTRY indefinitely.
  - MAX_FAILS and LOCKOUT_CYCLES are unused.

## Test plan
Default parameters, `CODE_LOCK_LOCKOUT_EN` defined unless noted.
- Correct code: keys 0,1,2,3 on cycles 10,12,14,16.
  - `digit_count` steps 1,2,3 then 0.
  - `unlocked`=1 for cycles 17–24 exactly.
  - `error` never asserts.
  - Keys pressed during cycles 17–24 are ignored.
- Wrong final digit: keys 0,1,2,0.
  - `error` is a single-cycle pulse the cycle after the 4th key; `unlocked` stays 0.
  - Next keys 0,1,2,3 unlock.
- Clear mid-entry:
  - Keys 0,1 then `key_clear` → `digit_count`=0, no `error`.
  - Then keys 0,1,2,3 unlock.
- Clear on the same cycle as the 3rd key: the key is dropped and `digit_count`=0.
- Lockout:
  - Three wrong codes → third `error` and `locked_out` rise together.
  - `locked_out` holds 16 cycles; keys during lockout are ignored.
  - After lockout, the correct code unlocks.
- Macro undefined: five wrong codes → five `error` pulses, `locked_out` always 0.
- Reset at cycle 20, mid-OPEN (and separately after 2 digits): next cycle `unlocked`=0, `digit_count`=0, fail count 0.
